// File: rtl/aes_round_pkg.sv
// Shared types and GF(2^8) helpers for the column-serial AES round datapath.
// The S-box is derived arithmetically (inverse then affine map) instead of a lookup ROM.
package aes_round_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Right-rotation of the T-table word for input rows 0..3 (index 0 is row 0).
  localparam logic [3:0][4:0] ROT_AMT = {5'd16, 5'd24, 5'd0, 5'd8};

  // Source byte in in_state for output column col, input row row.
  function automatic logic [3:0] byte_idx(input logic [1:0] col, input logic [1:0] row);
    logic [1:0] src_col;
    src_col = col + row;
    return {src_col, row};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    logic [7:0] bb;
    acc = 8'h00;
    aa  = a;
    bb  = b;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (bb[0] ? aa : 8'h00);
      aa  = xtime(aa);
      bb  = {1'b0, bb[7:1]};
    end
    return acc;
  endfunction

  // x^254 = x^-1 in GF(2^8); 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = x;
    res = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] amt);
    return (x >> amt) | (x << (6'd32 - {1'b0, amt}));
  endfunction

endpackage

// File: rtl/aes_table2.sv
// Combinational AES T-table entry: {S(x), S(x), 2*S(x), 3*S(x)}.
module aes_table2
  import aes_round_pkg::*;
(
  input  logic [7:0]  i_byte,
  output logic [31:0] o_t
);

  logic [7:0] w_s;
  logic [7:0] w_s2;

  // S-box value and its doubling feed the packed table word.
  always_comb begin
    w_s  = sbox(i_byte);
    w_s2 = xtime(w_s);
    o_t  = {w_s, w_s, w_s2, w_s2 ^ w_s};
  end

endmodule

// File: rtl/aes_round_seq.sv
// One AES encryption round, one output column per cycle, with valid/ready handshakes.
// Operands are captured on acceptance so the job is immune to upstream changes.
module aes_round_seq
  import aes_round_pkg::*;
#(
  parameter int ADD_KEY = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  state_e       r_state;
  state_e       w_state_nxt;
  logic [1:0]   r_col;
  logic [127:0] r_in_state;
  logic [127:0] r_key;
  logic [127:0] r_out_data;
  logic         r_out_valid;
  logic         r_in_ready;
  logic         r_busy;
  logic [31:0]  w_t   [4];
  logic [31:0]  w_rot [4];
  logic [31:0]  w_key_word;
  logic [31:0]  w_col;

  for (genvar g = 0; g < 4; g++) begin : g_row
    localparam logic [1:0] ROW = 2'(g);
    logic [3:0] w_idx;
    assign w_idx = byte_idx(r_col, ROW);
    aes_table2 u_tbl (
      .i_byte (r_in_state[{w_idx, 3'b000} +: 8]),
      .o_t    (w_t[g])
    );
    assign w_rot[g] = rotr32(w_t[g], ROT_AMT[g]);
  end

  // Column result: four rotated lookups plus optional round-key word.
  always_comb begin
    if (ADD_KEY != 0) begin
      w_key_word = r_key[{r_col, 5'b00000} +: 32];
    end else begin
      w_key_word = 32'h0000_0000;
    end
    w_col = w_rot[0] ^ w_rot[1] ^ w_rot[2] ^ w_rot[3] ^ w_key_word;
  end

  // Next-state decode for the job sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) w_state_nxt = ST_BUSY;
        else          w_state_nxt = ST_IDLE;
      end
      ST_BUSY: begin
        if (r_col == 2'd3) w_state_nxt = ST_DONE;
        else               w_state_nxt = ST_BUSY;
      end
      ST_DONE: begin
        if (out_ready) w_state_nxt = ST_IDLE;
        else           w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer state, operand capture and column-by-column result build-up.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_col       <= 2'd0;
      r_in_state  <= 128'h0;
      r_key       <= 128'h0;
      r_out_data  <= 128'h0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == ST_IDLE);
      r_busy     <= (w_state_nxt != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_in_state <= in_state;
            r_key      <= in_key;
            r_col      <= 2'd0;
          end
        end
        ST_BUSY: begin
          // col wraps 3->0 exactly as the last column is written.
          r_out_data[{r_col, 5'b00000} +: 32] <= w_col;
          r_col <= r_col + 2'd1;
          if (r_col == 2'd3) r_out_valid <= 1'b1;
        end
        ST_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq: vector table plus stall, reset-abort and streaming sequences.
module tb_aes_round_seq;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_state = 128'h0;
  logic [127:0] in_key = 128'h0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;
  logic         in_ready0, out_valid0, busy0;
  logic [127:0] out_data0;

  int n_checks = 0;
  int n_err = 0;

  logic [127:0] sbox_rows [16];

  aes_round_seq #(.ADD_KEY(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_key(in_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  aes_round_seq #(.ADD_KEY(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_state(in_state), .in_key(in_key), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .busy(busy0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic [127:0] exp1;
    logic [127:0] exp0;
    string        name;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [127:0] row;
    row = sbox_rows[x[7:4]];
    return row[8*(15 - int'(x[3:0])) +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Textbook round: SubBytes, ShiftRows, MixColumns, optional AddRoundKey.
  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k, input bit addk);
    logic [7:0] b [16];
    logic [7:0] sr [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = sb(s[8*i +: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4*c + r] = b[4*((c + r) % 4) + r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
      res[32*c +: 8]      = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      res[32*c + 8 +: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      res[32*c + 16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      res[32*c + 24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    if (addk) res = res ^ k;
    return res;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {127'h0, in_ready}, 128'h1);
    chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
    chk("rst_busy", {127'h0, busy}, 128'h0);
    chk("rst_out_data", out_data, 128'h0);
    reset_n = 1'b1;
  endtask

  task automatic run_job(input logic [127:0] s, input logic [127:0] k,
                         input logic [127:0] exp1, input logic [127:0] exp0, input string nm);
    int lat;
    lat = 0;
    @(negedge clk);
    chk({nm, "_in_ready"}, {127'h0, in_ready}, 128'h1);
    in_state = s; in_key = k; in_valid = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) begin
        in_valid = 1'b0;
        chk({nm, "_busy"}, {127'h0, busy}, 128'h1);
      end
      if (out_valid) lat = i;
    end
    chk({nm, "_latency"}, 128'(lat), 128'd5);
    chk({nm, "_data"}, out_data, exp1);
    chk({nm, "_data_nokey"}, out_data0, exp0);
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_ov_clear"}, {127'h0, out_valid}, 128'h0);
    chk({nm, "_ready_back"}, {127'h0, in_ready}, 128'h1);
    out_ready = 1'b0;
  endtask

  vec_t vecs [6];
  logic [127:0] held, exp_q [$], jobs [4];
  int bad, acc, got, last_acc, cyc;

  initial begin
    sbox_rows[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
    sbox_rows[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
    sbox_rows[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
    sbox_rows[3]  = 128'h04c723c31896059a071280e2eb27b275;
    sbox_rows[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
    sbox_rows[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
    sbox_rows[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
    sbox_rows[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
    sbox_rows[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
    sbox_rows[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
    sbox_rows[10] = 128'he0323a0a4906245cc2d3ac629195e479;
    sbox_rows[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
    sbox_rows[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
    sbox_rows[13] = 128'h703eb5664803f60e613557b986c11d9e;
    sbox_rows[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
    sbox_rows[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;

    vecs[0] = '{128'h0, 128'h0, {16{8'h63}}, {16{8'h63}}, "zero"};
    vecs[1] = '{128'h0, {128{1'b1}}, {16{8'h9c}}, {16{8'h63}}, "key_ones"};
    vecs[2] = '{128'h1, 128'h0, {{12{8'h63}}, 32'h427c7c5d}, {{12{8'h63}}, 32'h427c7c5d}, "byte0"};
    vecs[3] = '{128'h0848f8e92a8dc69a2be2f4a0bee33d19, 128'h05766c2a3939a323b12c548817fefaa0,
                128'h49506a0243ea5b6b2b359f68f27f9ca4, 128'h4c2606287ad3f8489a19cbe0e5816604, "fips_r1"};
    vecs[4] = '{128'h00112233445566778899aabbccddeeff, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0,
                128'h0, 128'h0, "pattern_a"};
    vecs[5] = '{128'hdeadbeef0123456789abcdeffedcba98, 128'h13579bdf2468ace0fdb97531eca86420,
                128'h0, 128'h0, "pattern_b"};
    for (int i = 4; i < 6; i++) begin
      vecs[i].exp1 = model(vecs[i].st, vecs[i].key, 1'b1);
      vecs[i].exp0 = model(vecs[i].st, vecs[i].key, 1'b0);
    end

    do_reset();
    for (int i = 0; i < 6; i++) run_job(vecs[i].st, vecs[i].key, vecs[i].exp1, vecs[i].exp0, vecs[i].name);

    // Stall in DONE with out_ready low; a new request must be ignored.
    @(negedge clk);
    in_state = vecs[3].st; in_key = vecs[3].key; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("stall_ov", {127'h0, out_valid}, 128'h1);
    held = out_data;
    chk("stall_first", held, vecs[3].exp1);
    bad = 0;
    in_state = 128'h0; in_key = 128'h0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== vecs[3].exp1 || in_ready !== 1'b0) bad++;
    end
    chk("stall_hold", 128'(bad), 128'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_release_ov", {127'h0, out_valid}, 128'h0);
    chk("stall_release_ready", {127'h0, in_ready}, 128'h1);
    @(negedge clk);
    chk("stall_no_accept", {127'h0, busy}, 128'h0);

    // Reset during the second BUSY cycle aborts the job.
    in_state = vecs[5].st; in_key = vecs[5].key; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_ready", {127'h0, in_ready}, 128'h1);
    chk("abort_ov", {127'h0, out_valid}, 128'h0);
    chk("abort_busy", {127'h0, busy}, 128'h0);
    chk("abort_data", out_data, 128'h0);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    chk("abort_no_ov", 128'(bad), 128'd0);
    run_job(vecs[4].st, vecs[4].key, vecs[4].exp1, vecs[4].exp0, "after_abort");

    // Streaming with in_valid and out_ready held high.
    for (int j = 0; j < 4; j++) jobs[j] = {$urandom, $urandom, $urandom, $urandom};
    acc = 0; got = 0; last_acc = -1; cyc = 0;
    out_ready = 1'b1;
    while (cyc < 60 && got < 4) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (exp_q.size() > 0) begin
          chk($sformatf("stream_data%0d", got), out_data, exp_q.pop_front());
        end else begin
          chk("stream_spurious", {127'h0, out_valid}, 128'h0);
        end
        got++;
      end
      if (acc < 4) begin
        in_state = jobs[acc]; in_key = jobs[(acc + 1) % 4]; in_valid = 1'b1;
        if (in_ready) begin
          if (last_acc >= 0) chk($sformatf("stream_gap%0d", acc), 128'(cyc - last_acc), 128'd6);
          last_acc = cyc;
          exp_q.push_back(model(in_state, in_key, 1'b1));
          acc++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("stream_count", 128'(got), 128'd4);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_round_seq.md
AES_ROUND_SEQ -- requirements
Module: aes_round_seq

Interface
REQ-001 SHALL have parameter ADD_KEY, default 1; when 1 the round key is XORed into the result (AddRoundKey), when 0 the key input is ignored.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, meaning the upstream state and key are valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept a job.
REQ-006 SHALL have port in_state, input, 128, the AES state; byte i is bits [8i+7:8i], and column c is bytes 4c..4c+3 with row r = byte 4c+r.
REQ-007 SHALL have port in_key, input, 128, the round key; key word c is bits [32c+31:32c].
REQ-008 SHALL have port out_valid, output, 1, meaning the round result is valid.
REQ-009 SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-010 SHALL have port out_data, output, 128, the round result, using the same byte layout as in_state.
REQ-011 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-012 SHALL compute one AES encryption round per job: SubBytes, ShiftRows, MixColumns, then AddRoundKey when ADD_KEY=1.
REQ-013 SHALL use T-table lookups: T(x) = {S(x), S(x), 2·S(x), 3·S(x)} (bits [31:24] down to [7:0]), with GF(2^8) multiplication.
REQ-014 SHALL form output column c as the XOR over r=0..3 of rotr(T(in_state byte 4·((c+r) mod 4)+r), 8·((1−r) mod 4)), XORed with key word c.
REQ-015 SHALL implement FSM states IDLE, BUSY and DONE, with a 2-bit column counter col.
REQ-016 SHALL drive in_ready = 1 only in IDLE.
REQ-017 SHALL, on in_valid && in_ready, register in_state and in_key, set col=0 and move to BUSY.
REQ-018 SHALL, in BUSY, compute column col using four parallel lookups, write it into out_data bits [32·col+31:32·col], and increment col.
REQ-019 SHALL, when col=3, write the final column, move to DONE and set out_valid=1.
REQ-020 SHALL assert out_valid in the 5th cycle after the handshake cycle (handshake cycle = 0), i.e. 5-cycle latency and one job per 6 cycles minimum.
REQ-021 SHALL hold out_data and out_valid stable in DONE while out_ready=0.
REQ-022 SHALL, on out_valid && out_ready, clear out_valid and return to IDLE; in_ready rises the following cycle.
REQ-023 SHALL ignore in_valid, in_state and in_key outside IDLE; registered operands SHALL NOT change mid-job.
REQ-024 SHALL leave out_valid unaffected by out_ready while in IDLE or BUSY.
REQ-025 SHALL wrap col from 3 to 0 only on the BUSY-to-DONE transition.

Reset
REQ-026 SHALL, when reset_n=0 at a clock edge, force state IDLE, col=0, out_valid=0, out_data=0, busy=0 and drive in_ready=1 after the edge.
REQ-027 SHALL, on reset asserted in BUSY or DONE, abort the job and discard it, producing no out_valid for it.

Structure
REQ-028 SHALL take the FSM state enum, the rotation-amount constants and the byte/column index helper from shared package aes_round_pkg.
REQ-029 SHALL instantiate the existing combinational T-table module aes_table2 four times (one per row); no other sub-module.

Verification
REQ-030 SHALL test: state=0, key=0, ADD_KEY=1 -> out_data = 128'h6363...63 (16 bytes), with out_valid in cycle 5.
REQ-031 SHALL test: state=0, key=all-ones -> out_data = 128'h9c9c...9c.
REQ-032 SHALL test: state byte0=0x01 and all other bytes 0, key=0 -> out_data bits [31:0]=32'h427c7c5d and bits [127:32] all bytes 0x63.
REQ-033 SHALL test: out_ready held 0 for 10 cycles -> out_data stable, in_ready=0, and a new in_valid during that time is not accepted.
REQ-034 SHALL test: reset_n=0 in cycle 2 of BUSY -> out_valid stays 0, in_ready=1 after the edge, and the next job returns its correct result.
REQ-035 SHALL test: back-to-back jobs with in_valid and out_ready always 1 -> accepts spaced exactly 6 cycles and each result matches a software AES round model.
